// File: rtl/playback_sequencer.sv
// Walks the note RAM from index 0 up to the valid-note bound. Each note is held
// for NOTE_TICKS cycles, then followed by GAP_TICKS cycles of silence.
module playback_sequencer #(
   parameter int NOTE_W     = 6,
   parameter int ADDR_W     = 6,
   parameter int NOTE_TICKS = 12_500_000,
   parameter int GAP_TICKS  = 1_250_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic              pause,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] i_note,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [NOTE_W-1:0] rd_data,
   output logic [NOTE_W-1:0] note_code,
   output logic              note_valid,
   output logic [ADDR_W-1:0] pos,
   output logic              playing,
   output logic              paused,
   output logic              edit_lock,
   output logic              done
);

   localparam int CNT_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0]  NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_TICKS - 1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [NOTE_W-1:0] NOTE_ZERO = NOTE_W'(0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0] r_idx, w_idx_nxt;
   logic [ADDR_W-1:0] r_len, w_len_nxt;
   logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
   logic [ADDR_W-1:0] r_pos, w_pos_nxt;
   logic [NOTE_W-1:0] r_note_code, w_note_code_nxt;
   logic              r_note_valid, w_note_valid_nxt;
   logic              r_playing, w_playing_nxt;
   logic              r_paused, w_paused_nxt;
   logic              r_done, w_done_nxt;

   logic w_abort, w_start, w_pause_ok, w_frozen, w_note_last, w_gap_last, w_more;

   assign w_abort     = stop && (r_state != S_IDLE);
   assign w_start     = play && !stop && (i_note != ADDR_ZERO) && (r_state == S_IDLE);
   assign w_pause_ok  = pause && ((r_state == S_HOLD) || (r_state == S_GAP));
   // Paused value after this edge; the count stands still whenever it is set.
   assign w_frozen    = r_paused ^ w_pause_ok;
   assign w_note_last = (r_cnt == NOTE_LAST);
   assign w_gap_last  = (r_cnt == GAP_LAST);
   assign w_more      = ({1'b0, r_idx} + {1'b0, ADDR_ONE}) < {1'b0, r_len};

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= CNT_ZERO;
         r_idx        <= ADDR_ZERO;
         r_len        <= ADDR_ZERO;
         r_rd_addr    <= ADDR_ZERO;
         r_pos        <= ADDR_ZERO;
         r_note_code  <= NOTE_ZERO;
         r_note_valid <= 1'b0;
         r_playing    <= 1'b0;
         r_paused     <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_len        <= w_len_nxt;
         r_rd_addr    <= w_rd_addr_nxt;
         r_pos        <= w_pos_nxt;
         r_note_code  <= w_note_code_nxt;
         r_note_valid <= w_note_valid_nxt;
         r_playing    <= w_playing_nxt;
         r_paused     <= w_paused_nxt;
         r_done       <= w_done_nxt;
      end
   end

   // Next-state selection
   always_comb begin
      w_state_nxt = r_state;
      if (w_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) w_state_nxt = S_FETCH;
               else         w_state_nxt = S_IDLE;
            end
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_HOLD;
            S_HOLD: begin
               if (!w_frozen && w_note_last) w_state_nxt = S_GAP;
               else                          w_state_nxt = S_HOLD;
            end
            S_GAP: begin
               if (w_frozen || !w_gap_last) w_state_nxt = S_GAP;
               else if (w_more || loop_en)  w_state_nxt = S_FETCH;
               else                         w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Next values of counters, indices and registered outputs
   always_comb begin
      w_cnt_nxt        = r_cnt;
      w_idx_nxt        = r_idx;
      w_len_nxt        = r_len;
      w_rd_addr_nxt    = r_rd_addr;
      w_pos_nxt        = r_pos;
      w_note_code_nxt  = r_note_code;
      w_note_valid_nxt = r_note_valid;
      w_paused_nxt     = r_paused;
      w_done_nxt       = 1'b0;
      w_playing_nxt    = (w_state_nxt != S_IDLE);
      if (w_abort) begin
         w_cnt_nxt        = CNT_ZERO;
         w_idx_nxt        = ADDR_ZERO;
         w_rd_addr_nxt    = ADDR_ZERO;
         w_pos_nxt        = ADDR_ZERO;
         w_note_code_nxt  = NOTE_ZERO;
         w_note_valid_nxt = 1'b0;
         w_paused_nxt     = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cnt_nxt        = CNT_ZERO;
               w_idx_nxt        = ADDR_ZERO;
               w_rd_addr_nxt    = ADDR_ZERO;
               w_pos_nxt        = ADDR_ZERO;
               w_note_code_nxt  = NOTE_ZERO;
               w_note_valid_nxt = 1'b0;
               w_paused_nxt     = 1'b0;
               if (w_start) w_len_nxt = i_note;
               else         w_len_nxt = r_len;
            end
            S_FETCH: begin
               w_cnt_nxt = r_cnt;
            end
            S_WAIT: begin
               w_note_code_nxt  = rd_data;
               w_note_valid_nxt = (rd_data != NOTE_ZERO);
               w_cnt_nxt        = CNT_ZERO;
            end
            S_HOLD: begin
               w_paused_nxt = w_frozen;
               if (w_frozen) begin
                  w_cnt_nxt = r_cnt;
               end else if (w_note_last) begin
                  w_note_code_nxt  = NOTE_ZERO;
                  w_note_valid_nxt = 1'b0;
                  w_cnt_nxt        = CNT_ZERO;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
            S_GAP: begin
               w_paused_nxt = w_frozen;
               if (w_frozen) begin
                  w_cnt_nxt = r_cnt;
               end else if (!w_gap_last) begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end else if (w_more) begin
                  w_cnt_nxt     = CNT_ZERO;
                  w_idx_nxt     = r_idx + ADDR_ONE;
                  w_pos_nxt     = r_idx + ADDR_ONE;
                  w_rd_addr_nxt = r_idx + ADDR_ONE;
               end else if (loop_en) begin
                  // The bound is re-read on every loop restart.
                  w_cnt_nxt     = CNT_ZERO;
                  w_idx_nxt     = ADDR_ZERO;
                  w_pos_nxt     = ADDR_ZERO;
                  w_rd_addr_nxt = ADDR_ZERO;
                  w_len_nxt     = i_note;
               end else begin
                  w_cnt_nxt  = CNT_ZERO;
                  w_done_nxt = 1'b1;
               end
            end
            S_DONE: begin
               w_cnt_nxt        = CNT_ZERO;
               w_idx_nxt        = ADDR_ZERO;
               w_rd_addr_nxt    = ADDR_ZERO;
               w_pos_nxt        = ADDR_ZERO;
               w_note_code_nxt  = NOTE_ZERO;
               w_note_valid_nxt = 1'b0;
               w_paused_nxt     = 1'b0;
            end
            default: begin
               w_cnt_nxt        = CNT_ZERO;
               w_idx_nxt        = ADDR_ZERO;
               w_rd_addr_nxt    = ADDR_ZERO;
               w_pos_nxt        = ADDR_ZERO;
               w_note_code_nxt  = NOTE_ZERO;
               w_note_valid_nxt = 1'b0;
               w_paused_nxt     = 1'b0;
            end
         endcase
      end
   end

   assign rd_addr    = r_rd_addr;
   assign note_code  = r_note_code;
   assign note_valid = r_note_valid;
   assign pos        = r_pos;
   assign playing    = r_playing;
   assign paused     = r_paused;
   assign edit_lock  = r_playing;
   assign done       = r_done;

endmodule
